mod_n_countdown_timer: RTL and testbench

//  Multi-digit modulo-N down counter (countdown timer). It is the counting-down

---
 rtl/mod_n_pkg.sv | 21 ++
 rtl/mod_n_digit.sv | 32 +++
 rtl/mod_n_countdown_timer.sv | 134 +++++++++++++
 tb/tb_mod_n_countdown_timer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_n_pkg.sv
// Shared types, default geometry and helpers for the modulo-N countdown timer.
package mod_n_pkg;

    localparam int unsigned N_DEF      = 10;
    localparam int unsigned WIDTH_DEF  = 4;
    localparam int unsigned DIGITS_DEF = 2;
    localparam int unsigned TOTAL_W    = DIGITS_DEF * WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } tmr_state_t;

    // Limit a loaded digit to the largest legal value of a radix-n digit.
    function automatic int unsigned clamp_digit(input int unsigned d, input int unsigned n);
        return (d >= n) ? (n - 1) : d;
    endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-N down-counting digit.
//  clk, reset     : clock, synchronous active-high reset
//  ld, ld_val     : parallel load (has priority over dec)
//  dec            : borrow in; decrement this digit
//  val            : registered digit value
//  borrow_out     : dec arriving while the digit is 0 (it wraps to N-1)
module mod_n_digit #(
    parameter int unsigned N     = 10,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dec,
    output logic [WIDTH-1:0] val,
    output logic             borrow_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            val <= '0;
        end else if (ld) begin
            val <= ld_val;
        end else if (dec) begin
            val <= (val == '0) ? WIDTH'(N - 1) : val - WIDTH'(1);
        end
    end

    assign borrow_out = dec & (val == '0);

endmodule

// File: rtl/mod_n_countdown_timer.sv
// Multi-digit modulo-N countdown timer with pause, done pulse and optional auto-reload.
//  clk, reset : clock, synchronous active-high reset
//  en         : rate strobe from the prescaler
//  load       : capture load_val (digits clamped to N-1) into count and reload
//  load_val   : start value, digit 0 in LSBs
//  start      : begin / resume counting
//  pause      : freeze counting while in RUN
//  count      : current value, digit 0 in LSBs
//  busy       : high in RUN or PAUSE
//  done       : one-cycle pulse in the cycle count becomes 0
module mod_n_countdown_timer
    import mod_n_pkg::*;
#(
    parameter int unsigned N           = N_DEF,
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned DIGITS      = DIGITS_DEF,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic [DIGITS*WIDTH-1:0] load_val,
    input  logic                    start,
    input  logic                    pause,
    output logic [DIGITS*WIDTH-1:0] count,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned TW = DIGITS * WIDTH;

    tmr_state_t    state;
    logic [TW-1:0] reload;
    logic [TW-1:0] load_clamped;
    logic [TW-1:0] digit_ld_val;
    logic [DIGITS:0] dec_chain;
    logic          dec_en;
    logic          underflow;
    logic          restart;
    logic          digit_ld;
    logic          count_zero;
    logic          count_one;

    // Per-digit clamp of the load value.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_clamped[i*WIDTH +: WIDTH] =
                WIDTH'(clamp_digit(32'(load_val[i*WIDTH +: WIDTH]), N));
        end
    end

    assign count_zero = (count == '0);
    assign count_one  = (count == TW'(1));

    // A decrement step happens only in RUN on a strobe not overridden by load/pause.
    assign dec_en    = (state == RUN) & en & ~load & ~pause;
    assign dec_chain[0] = dec_en;
    // A borrow out of the top digit means the count was already 0: reload point.
    assign underflow = dec_chain[DIGITS];
    assign restart   = (state == DONE) & start & ~load & (reload != '0);

    assign digit_ld     = load | restart | (AUTO_RELOAD & underflow);
    assign digit_ld_val = load ? load_clamped : reload;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        mod_n_digit #(
            .N     (N),
            .WIDTH (WIDTH)
        ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .ld         (digit_ld),
            .ld_val     (digit_ld_val[g*WIDTH +: WIDTH]),
            .dec        (dec_chain[g]),
            .val        (count[g*WIDTH +: WIDTH]),
            .borrow_out (dec_chain[g+1])
        );
    end

    // Control FSM, reload register and registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            reload <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state  <= IDLE;
                reload <= load_clamped;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !count_zero) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (en && count_one) begin
                            done <= 1'b1;
                            if (!AUTO_RELOAD) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!pause && start) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        if (restart) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_n_countdown_timer.sv
// Bench for mod_n_countdown_timer: one stop-on-expiry and one auto-reload instance
// share stimulus; a behavioural model pushes expected outputs to a scoreboard.
module tb_mod_n_countdown_timer;
    import mod_n_pkg::*;

    localparam int unsigned N  = 10;
    localparam int unsigned W  = 4;
    localparam int unsigned D  = 2;
    localparam int unsigned TW = D * W;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          reset, en, load, start, pause;
    logic [TW-1:0] load_val;
    logic [TW-1:0] count0, count1;
    logic          busy0, busy1, done0, done1;

    typedef struct packed {
        logic [TW-1:0] count;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   m_st[2];
    int   m_c[2];
    int   m_r[2];
    logic m_busy[2];
    logic m_done[2];

    always #5 clk = ~clk;

    mod_n_countdown_timer #(.N(N), .WIDTH(W), .DIGITS(D), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .count(count0), .busy(busy0), .done(done0)
    );

    mod_n_countdown_timer #(.N(N), .WIDTH(W), .DIGITS(D), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .count(count1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Integer count -> packed digits.
    function automatic logic [TW-1:0] to_digits(input int v);
        logic [TW-1:0] r;
        int            t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(D); i++) begin
            r[i*W +: W] = W'(t % int'(N));
            t = t / int'(N);
        end
        return r;
    endfunction

    // Packed load value -> clamped integer count.
    function automatic int clamp_value(input logic [TW-1:0] x);
        int v, mult, d;
        v = 0;
        mult = 1;
        for (int i = 0; i < int'(D); i++) begin
            d = int'(x[i*W +: W]);
            if (d >= int'(N)) d = int'(N) - 1;
            v += d * mult;
            mult *= int'(N);
        end
        return v;
    endfunction

    task automatic model_step(input int k);
        bit autor;
        autor = (k == 1);
        if (reset) begin
            m_st[k] = M_IDLE; m_c[k] = 0; m_r[k] = 0; m_done[k] = 1'b0;
        end else begin
            m_done[k] = 1'b0;
            if (load) begin
                m_c[k] = clamp_value(load_val);
                m_r[k] = m_c[k];
                m_st[k] = M_IDLE;
            end else begin
                case (m_st[k])
                    M_IDLE:  if (start && m_c[k] != 0) m_st[k] = M_RUN;
                    M_RUN: begin
                        if (pause) m_st[k] = M_PAUSE;
                        else if (en) begin
                            if (m_c[k] == 0) m_c[k] = m_r[k];
                            else begin
                                m_c[k] = m_c[k] - 1;
                                if (m_c[k] == 0) begin
                                    m_done[k] = 1'b1;
                                    if (!autor) m_st[k] = M_DONE;
                                end
                            end
                        end
                    end
                    M_PAUSE: if (!pause && start) m_st[k] = M_RUN;
                    default: if (start && m_r[k] != 0) begin
                        m_st[k] = M_RUN;
                        m_c[k] = m_r[k];
                    end
                endcase
            end
        end
        m_busy[k] = (m_st[k] == M_RUN) || (m_st[k] == M_PAUSE);
    endtask

    // One clock: predict, push, clock, pop and compare both instances.
    task automatic cyc();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            e.count = to_digits(m_c[k]);
            e.busy  = m_busy[k];
            e.done  = m_done[k];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("count0", 32'(count0), 32'(e.count));
        check("busy0",  32'(busy0),  32'(e.busy));
        check("done0",  32'(done0),  32'(e.done));
        e = sb_q.pop_front();
        check("count1", 32'(count1), 32'(e.count));
        check("busy1",  32'(busy1),  32'(e.busy));
        check("done1",  32'(done1),  32'(e.done));
    endtask

    initial begin
        int strobes, done_at, n, last_done, held;
        reset = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = '0;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_IDLE; m_c[k] = 0; m_r[k] = 0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
        end
        #2;

        // 1. reset, then start with count 0 is ignored
        cyc(); cyc();
        check("rst_count", 32'(count0), 32'h00);
        check("rst_busy",  32'(busy0),  32'h0);
        reset = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        check("start_at_zero_busy", 32'(busy0), 32'h0);
        cyc();

        // 2. full countdown from 23
        load = 1'b1; load_val = 8'h23; cyc(); load = 1'b0;
        check("load23", 32'(count0), 32'h23);
        start = 1'b1; en = 1'b1; cyc(); start = 1'b0;
        strobes = 0; done_at = -1;
        while (strobes < 40 && done_at < 0) begin
            cyc();
            strobes++;
            if (done0) done_at = strobes;
        end
        check("done_strobe", 32'(done_at), 32'd23);
        check("done_count", 32'(count0), 32'h00);
        cyc();
        check("after_done_busy", 32'(busy0), 32'h0);
        check("after_done_hold", 32'(count0), 32'h00);

        // 3. pause at 15, hold with en=1, resume, pause+start together
        load = 1'b1; load_val = 8'h23; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        n = 0;
        while (m_c[0] != 15 && n < 20) begin cyc(); n++; end
        check("reach15", 32'(count0), 32'h15);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check("pause_hold", 32'(count0), 32'h15);
        check("pause_busy", 32'(busy0), 32'h1);
        pause = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        check("resume_no_step", 32'(count0), 32'h15);
        cyc();
        check("resume_step", 32'(count0), 32'h14);
        pause = 1'b1; cyc();
        start = 1'b1; cyc(); cyc();
        check("pause_wins", 32'(count0), 32'h14);
        pause = 1'b0; start = 1'b0; cyc();

        // 4. clamping on load
        load = 1'b1; load_val = 8'h9F; cyc();
        check("clamp_9F", 32'(count0), 32'h99);
        load_val = 8'hA0; cyc(); load = 1'b0;
        check("clamp_A0", 32'(count0), 32'h90);

        // 5. auto-reload period and en-low hold
        load = 1'b1; load_val = 8'h03; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        last_done = -1;
        for (int i = 0; i < 13; i++) begin
            cyc();
            if (done1) begin
                if (last_done >= 0) check("reload_period", 32'(i - last_done), 32'd4);
                last_done = i;
            end
        end
        en = 1'b0;
        held = int'(count1);
        for (int i = 0; i < 3; i++) cyc();
        check("en_low_hold", 32'(count1), 32'(held));
        check("en_low_busy", 32'(busy1), 32'h1);
        en = 1'b1;

        // 6a. load during a run aborts without done
        load = 1'b1; load_val = 8'h10; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        n = 0;
        while (m_c[0] != 7 && n < 20) begin cyc(); n++; end
        check("reach07", 32'(count0), 32'h07);
        load = 1'b1; load_val = 8'h50; cyc(); load = 1'b0;
        check("abort_count", 32'(count0), 32'h50);
        check("abort_busy",  32'(busy0),  32'h0);
        check("abort_done",  32'(done0),  32'h0);

        // 6b. reset during a run
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        check("midrst_count", 32'(count0), 32'h00);
        check("midrst_busy",  32'(busy0),  32'h0);
        en = 1'b0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
